// File: rtl/mips32_mem_arbiter.sv
// rtl/mips32_mem_arbiter.sv - shared I/D memory arbiter between the IF and MEM stages
// One transaction at a time; data wins unless a fetch has waited through STREAK_MAX data grants.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int RD_LAT     = 2,
  parameter int STREAK_MAX = 3
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  input  logic          flush,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_LOAD  = 2'd2;
  localparam logic [1:0] OWN_STORE = 2'd3;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(RD_LAT - 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

  logic [1:0]    r_state;
  logic [1:0]    r_owner;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_streak;
  logic          r_kill;
  logic          r_i_gnt;
  logic          r_i_rvalid;
  logic [DW-1:0] r_i_rdata;
  logic          r_d_gnt;
  logic          r_d_done;
  logic [DW-1:0] r_d_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_busy;

  logic          w_i_eff;
  logic          w_d_win;
  logic          w_i_win;
  logic [SW-1:0] w_streak_inc;

  // A flushed fetch request is treated as absent for both arbitration and streak accounting.
  always_comb begin
    w_i_eff      = i_req & ~flush;
    w_d_win      = d_req & (~w_i_eff | (r_streak < STREAK_TOP));
    w_i_win      = ~w_d_win & w_i_eff;
    w_streak_inc = (r_streak == STREAK_TOP) ? r_streak : r_streak + SW'(1);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_kill      <= 1'b0;
      r_i_gnt     <= 1'b0;
      r_i_rvalid  <= 1'b0;
      r_i_rdata   <= '0;
      r_d_gnt     <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_i_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_d_win) begin
            r_owner     <= d_we ? OWN_STORE : OWN_LOAD;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_en    <= 1'b1;
            r_mem_we    <= d_we;
            r_d_gnt     <= 1'b1;
            r_streak    <= w_i_eff ? w_streak_inc : '0;
            r_busy      <= 1'b1;
            r_state     <= S_ACCESS;
          end else if (w_i_win) begin
            r_owner    <= OWN_FETCH;
            r_mem_addr <= i_addr;
            r_mem_en   <= 1'b1;
            r_i_gnt    <= 1'b1;
            r_streak   <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_owner == OWN_FETCH && flush) begin
            r_kill <= 1'b1;
          end
          if (r_owner == OWN_STORE) begin
            r_d_done <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_owner == OWN_FETCH && flush) begin
            r_kill <= 1'b1;
          end
          // Last WAIT cycle: memory data is valid now, so capture and raise the response.
          if (r_cnt == '0) begin
            if (r_owner == OWN_FETCH) begin
              r_i_rdata  <= mem_rdata;
              r_i_rvalid <= ~(r_kill | flush);
            end else begin
              r_d_rdata <= mem_rdata;
              r_d_done  <= 1'b1;
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          r_kill  <= 1'b0;
          r_owner <= OWN_NONE;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign i_gnt     = r_i_gnt;
  assign i_rvalid  = r_i_rvalid;
  assign i_rdata   = r_i_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
